mem_req_arbiter: RTL
====================

// Module: mem_req_arbiter
// PURPOSE
//  Shares one sram-like memory port between the instruction-fetch master (pre-IF/IF) and the data master (EX/MEM).
//  Grants one request per cycle: data has priority, with a starvation guard for fetch.
//  Records the owner of every accepted request in order, and routes each in-order response (data_ok/rdata) back to that owner.
//  Sits between the CPU pipeline and the AXI bridge or cache.
// PARAMETERS
//  MAX_OUT       2   max accepted-but-unanswered requests (1..4); also the depth of the owner FIFO
//  STARVE_LIMIT  4   consecutive data grants with fetch pending before fetch is forced a grant (>=1)
// PORTS
//  clk           in   1   clock
//  resetn        in   1   reset, synchronous, active-low
//  inst_req      in   1   fetch request; held with its fields until inst_addr_ok
//  inst_addr     in   32  fetch address (read only, size fixed 2'b10)
//  inst_addr_ok  out  1   fetch request accepted this cycle
//  inst_data_ok  out  1   fetch response valid this cycle
//  inst_rdata    out  32  fetch read data
//  data_req      in   1   data request; held with its fields until data_addr_ok
//  data_wr       in   1   1=write, 0=read
//  data_size     in   2   0=byte, 1=half, 2=word
//  data_addr     in   32  data address
//  data_wstrb    in   4   byte strobes (writes)
//  data_wdata    in   32  write data
//  data_addr_ok  out  1   data request accepted this cycle
//  data_data_ok  out  1   data response valid (read data or write completion)
//  data_rdata    out  32  data read data
//  mem_req       out  1   request to the shared port
//  mem_wr/mem_size/mem_addr/mem_wstrb/mem_wdata  out  1/2/32/4/32  fields of the granted request
//  mem_addr_ok   in   1   shared port accepted mem_req
//  mem_data_ok   in   1   in-order response from the shared port
//  mem_rdata     in   32  response data
// BEHAVIOUR
//  - Grant (combinational): only when cnt<MAX_OUT; force_inst=inst_req && starve_cnt==STARVE_LIMIT;
//    sel=INST if force_inst or !data_req, else DATA. mem_req=(inst_req|data_req) && cnt<MAX_OUT.
//  - mem_* fields are muxed from sel. For INST: wr=0, size=2, wstrb=0, wdata=0.
//  - The granted master's addr_ok = mem_addr_ok && mem_req. The other master's addr_ok=0.
//  - Accept (mem_req&&mem_addr_ok): push sel into the owner FIFO; cnt+1.
//  - Response (mem_data_ok): pop the head. If head==INST: inst_data_ok=1, inst_rdata=mem_rdata. If DATA: data_data_ok=1, data_rdata=mem_rdata.
//    Response latency through the block is 0 cycles (pure routing). rdata outputs pass mem_rdata through unconditionally.
//  - Push and pop in the same cycle: cnt unchanged, pointers both advance. Pointers wrap modulo MAX_OUT.
//  - cnt==MAX_OUT: mem_req=0, no addr_ok. A pop in that cycle does not enable a grant until the next cycle (grant uses registered cnt).
//  - mem_data_ok while cnt==0: protocol error. No pop, both data_ok=0, cnt stays 0 (simulation assertion fires).
//  - starve_cnt: clears on any inst accept or when !inst_req. Increments (saturating at STARVE_LIMIT) on a data accept while inst_req=1.
//  - Reset (resetn=0 at posedge), including mid-transaction: cnt=0, pointers=0, starve_cnt=0, outstanding owners discarded.
//    While resetn=0: all *_addr_ok=0, *_data_ok=0, mem_req=0. Responses to pre-reset requests are the downstream's responsibility to squash.
//  - Pipeline flush does not touch this block: the fetch stage discards stale inst_data_ok itself.
// STRUCTURE
//  - myCPU.h: `MST_INST 1'b0, `MST_DATA 1'b1, `MEM_SIZE_WORD 2'b10.
//  - Sub-module mem_arb_id_fifo: 1-bit wide, MAX_OUT deep. Provides push, pop, head, cnt, full, empty; synchronous active-low reset.
//  - Top contains the grant mux, starve counter and response demux.
// TESTING
//  1 Fetch only, mem_addr_ok=1, data_ok 2 cycles later, rdata=0x02800000 -> inst_addr_ok same cycle, inst_data_ok/rdata routed, data_data_ok=0.
//  2 inst_req and data_req same cycle (data wr, addr 0x1c000010, wstrb 0xF) -> data granted, mem_wr=1, inst_addr_ok=0; inst granted next cycle.
//  3 MAX_OUT=2: two accepts, mem_data_ok held 0 -> third cycle mem_req=0 despite pending req; one response -> grant resumes next cycle.
//  4 Accept order INST,DATA,INST; responses 0xA,0xB,0xC -> inst gets 0xA, data 0xB, inst 0xC; push+pop same cycle keeps cnt.
//  5 data_req and inst_req held continuously, STARVE_LIMIT=4 -> 4 data grants, then 1 inst grant, then data again.
//  6 resetn=0 with cnt=2 -> next cycle cnt=0, mem_req=0; stray mem_data_ok with cnt=0 -> no data_ok, assertion flagged.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter slice.
package mem_req_arbiter_pkg;

  // Owner of a request on the shared memory port.
  typedef enum logic {
    MST_INST = 1'b0,
    MST_DATA = 1'b1
  } mst_e;

  // Fetches are always full-word reads.
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// 1-bit wide, DEPTH-deep FIFO holding the owner of each accepted request,
// oldest at the head. Pushes when full and pops when empty are ignored.
module mem_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          push_id,
  input  logic          pop,
  output logic          head_id,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] ids_q, ids_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Status flags and head entry.
  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    empty   = (cnt_q == '0);
    cnt     = cnt_q;
    head_id = ids_q[rd_ptr_q];
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      ids_d[wr_ptr_q] = push_id;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset; stored owners are discarded.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ids_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ids_q    <= ids_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between the fetch and data masters.
// Data wins arbitration unless fetch has been starved for STARVE_LIMIT data
// grants; responses are routed back in order using the owner FIFO.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  mst_e          sel;
  logic          force_inst;
  logic          can_grant;
  logic          accept;
  logic          resp_pop;
  logic          head_id;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] out_cnt;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  // Grant selection and request-field mux toward the shared port.
  always_comb begin
    can_grant    = resetn && !fifo_full;
    force_inst   = inst_req && (starve_cnt_q == SW'(STARVE_LIMIT));
    sel          = (force_inst || !data_req) ? MST_INST : MST_DATA;
    mem_req      = (inst_req || data_req) && can_grant;
    accept       = mem_req && mem_addr_ok;
    inst_addr_ok = accept && (sel == MST_INST);
    data_addr_ok = accept && (sel == MST_DATA);
    if (sel == MST_INST) begin
      mem_wr    = 1'b0;
      mem_size  = MEM_SIZE_WORD;
      mem_addr  = inst_addr;
      mem_wstrb = '0;
      mem_wdata = '0;
    end else begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end
  end

  // Route each in-order response to the owner at the FIFO head.
  always_comb begin
    resp_pop     = resetn && mem_data_ok && !fifo_empty;
    inst_data_ok = resp_pop && (head_id == MST_INST);
    data_data_ok = resp_pop && (head_id == MST_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  // Count data grants taken while fetch waits; saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!inst_req || inst_addr_ok) begin
      starve_cnt_d = '0;
    end else if (data_addr_ok && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (!resetn) starve_cnt_q <= '0;
    else         starve_cnt_q <= starve_cnt_d;
  end

  // A response with nothing outstanding is a downstream protocol error.
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(mem_data_ok && (out_cnt == '0)))
        else $warning("mem_req_arbiter: mem_data_ok with no outstanding request");
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .push_id (sel),
    .pop     (resp_pop),
    .head_id (head_id),
    .cnt     (out_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
